fifo_fwft_thresh: RTL and testbench

Parametrised first-word-fall-through FIFO. It supports any depth of 2 or more, including non-power-of-two, and adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and overflow/underflow error pulses. It is the general-purpose successor FIFO for datapath buffering between accelerator stages. It uses a single clock domain.

---
 rtl/fifo_fwft_thresh.sv | 90 +++++++++
 tb/tb_fifo_fwft_thresh.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_thresh.sv
// First-word-fall-through FIFO of any depth >= 2, with occupancy count, threshold flags, flush and error pulses.
// Write-to-dout latency is one cycle; writes while full (without a read) are dropped and flagged.
module fifo_fwft_thresh #(
  parameter int NUM_ENTRIES   = 64,
  parameter int DATA_W        = 16,
  parameter int AFULL_THRESH  = NUM_ENTRIES - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter int CNT_W         = $clog2(NUM_ENTRIES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              write_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              full_o,
  output logic              almost_full_o,
  input  logic              read_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o,
  output logic              almost_empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int PTR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  if (NUM_ENTRIES < 2) begin : g_bad_depth
    $error("fifo_fwft_thresh: NUM_ENTRIES must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > NUM_ENTRIES) begin : g_bad_afull
    $error("fifo_fwft_thresh: AFULL_THRESH out of range 1..NUM_ENTRIES");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > NUM_ENTRIES - 1) begin : g_bad_aempty
    $error("fifo_fwft_thresh: AEMPTY_THRESH out of range 0..NUM_ENTRIES-1");
  end

  logic [DATA_W-1:0] mem [NUM_ENTRIES];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic              wr_acc;
  logic              rd_acc;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_ENTRIES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o         = (count == CNT_W'(NUM_ENTRIES));
  assign empty_o        = (count == '0);
  assign almost_full_o  = (count >= CNT_W'(AFULL_THRESH));
  assign almost_empty_o = (count <= CNT_W'(AEMPTY_THRESH));
  assign count_o        = count;
  assign dout_o         = mem[rptr];

  assign wr_acc = write_i & (~full_o | read_i);
  assign rd_acc = read_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (wr_acc && !flush_i && !rst_i) begin
      mem[wptr] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= write_i & ~wr_acc;
      underflow_o <= read_i & ~rd_acc;
      if (wr_acc) begin
        wptr <= ptr_inc(wptr);
      end
      if (rd_acc) begin
        rptr <= ptr_inc(rptr);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_fwft_thresh.sv
// Randomized and directed bench for fifo_fwft_thresh; a queue model tracks expected contents and flags.
module tb_fifo_fwft_thresh;

  localparam int N5 = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0, flush = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       full, afull, empty, aempty, ovf, unf;
  logic [2:0] count;

  logic        rst64 = 1'b1, flush64 = 1'b0, wr64 = 1'b0, rd64 = 1'b0;
  logic [15:0] din64 = '0;
  logic [15:0] dout64;
  logic        full64, afull64, empty64, aempty64, ovf64, unf64;
  logic [6:0]  count64;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  q[$];
  bit          e_ovf = 1'b0, e_unf = 1'b0;
  logic [7:0]  last_pop = '0;
  logic [15:0] data64 [64];

  always #5 clk = ~clk;

  fifo_fwft_thresh #(.NUM_ENTRIES(5), .DATA_W(8), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .write_i(wr), .din_i(din),
    .full_o(full), .almost_full_o(afull), .read_i(rd), .dout_o(dout),
    .empty_o(empty), .almost_empty_o(aempty), .count_o(count),
    .overflow_o(ovf), .underflow_o(unf)
  );

  fifo_fwft_thresh dut64 (
    .clk_i(clk), .rst_i(rst64), .flush_i(flush64), .write_i(wr64), .din_i(din64),
    .full_o(full64), .almost_full_o(afull64), .read_i(rd64), .dout_o(dout64),
    .empty_o(empty64), .almost_empty_o(aempty64), .count_o(count64),
    .overflow_o(ovf64), .underflow_o(unf64)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock of the 5-entry FIFO: apply inputs, advance the model by the FIFO rules, compare all outputs.
  task automatic step(input logic w, input logic r, input logic [7:0] d,
                      input logic f, input logic rs);
    bit was_full, was_empty, wacc, racc;
    wr = w; rd = r; din = d; flush = f; rst = rs;
    @(posedge clk);
    was_full  = (q.size() == N5);
    was_empty = (q.size() == 0);
    if (rs || f) begin
      q.delete();
      e_ovf = 1'b0;
      e_unf = 1'b0;
    end else begin
      wacc  = w && (!was_full || r);
      racc  = r && !was_empty;
      e_ovf = w && !wacc;
      e_unf = r && !racc;
      if (racc) last_pop = q.pop_front();
      if (wacc) q.push_back(d);
    end
    #1;
    chk("count", 32'(count), q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == N5);
    chk("almost_full", afull, q.size() >= 4);
    chk("almost_empty", aempty, q.size() <= 1);
    chk("overflow", ovf, e_ovf);
    chk("underflow", unf, e_unf);
    if (q.size() != 0) chk("dout", dout, q[0]);
  endtask

  initial begin
    #1;
    step(0, 0, 8'h00, 0, 1);
    rst64 = 1'b0;
    chk("reset_empty", empty, 1);
    chk("reset_aempty", aempty, 1);

    // 1: first-word fall-through
    step(1, 0, 8'hA1, 0, 0);
    chk("s1_dout", dout, 8'hA1);
    chk("s1_aempty", aempty, 1);
    step(1, 0, 8'hA2, 0, 0);
    chk("s1_dout_hold", dout, 8'hA1);
    chk("s1_count", 32'(count), 2);

    // 2: fill, overflow, drain
    step(0, 0, 8'h00, 1, 0);
    for (int i = 1; i <= 5; i++) step(1, 0, 8'(i), 0, 0);
    chk("s2_full", full, 1);
    step(1, 0, 8'h06, 0, 0);
    chk("s2_ovf", ovf, 1);
    step(0, 0, 8'h00, 0, 0);
    chk("s2_ovf_end", ovf, 0);
    for (int i = 1; i <= 5; i++) begin
      chk("s2_seq", dout, i);
      step(0, 1, 8'h00, 0, 0);
    end
    chk("s2_empty", empty, 1);

    // 3: wrap both pointers
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 8'(8'h10 + i), 0, 0);
      chk("s3_dout", dout, 8'h10 + i);
      step(0, 1, 8'h00, 0, 0);
      chk("s3_cnt_le1", 32'(count <= 1), 1);
    end

    // 4: full with simultaneous read and write
    for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom), 0, 0);
    step(1, 1, 8'h77, 0, 0);
    chk("s4_count", 32'(count), 5);
    chk("s4_no_ovf", ovf, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00, 0, 0);
    chk("s4_last", last_pop, 8'h77);

    // 5: empty with read and write, then flush with a write
    step(1, 1, 8'h3C, 0, 0);
    chk("s5_unf", unf, 1);
    chk("s5_dout", dout, 8'h3C);
    step(1, 0, 8'h3D, 0, 0);
    step(1, 0, 8'h3E, 0, 0);
    chk("s5_count3", 32'(count), 3);
    step(1, 0, 8'h3F, 1, 0);
    chk("s5_flush_cnt", 32'(count), 0);
    chk("s5_flush_ovf", ovf, 0);
    chk("s5_flush_unf", unf, 0);

    // 6: reset mid-operation while reading
    for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom), 0, 0);
    step(0, 1, 8'h00, 0, 1);
    chk("s6_rst_cnt", 32'(count), 0);
    chk("s6_rst_empty", empty, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
    end
    step(0, 0, 8'h00, 0, 0);

    // Default configuration: fill 64, drain 64
    for (int i = 0; i < 64; i++) begin
      data64[i] = 16'($urandom);
      wr64 = 1'b1; din64 = data64[i];
      @(posedge clk); #1;
    end
    wr64 = 1'b0;
    chk("d64_full", full64, 1);
    chk("d64_count", 32'(count64), 64);
    chk("d64_afull", afull64, 1);
    chk("d64_no_ovf", ovf64, 0);
    for (int i = 0; i < 64; i++) begin
      chk("d64_data", dout64, data64[i]);
      rd64 = 1'b1;
      @(posedge clk); #1;
    end
    rd64 = 1'b0;
    chk("d64_empty", empty64, 1);
    chk("d64_aempty", aempty64, 1);
    chk("d64_no_unf", unf64, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
